// File: rtl/router_pkg.sv
// Shared routing definitions: header TID, header field placement and the
// packetizer state encoding, used by both packet builder and arbiter.
package router_pkg;

  localparam int unsigned ROUTING_HEADER = 4'hF;
  localparam int unsigned COUNT_W        = 8;
  localparam int unsigned HDR_DEST_Y_LSB = 0;

  typedef enum logic [1:0] {
    PKT_FILL   = 2'd0,
    PKT_HEADER = 2'd1,
    PKT_DRAIN  = 2'd2
  } pkt_state_e;

  function automatic int unsigned hdr_dest_x_lsb(input int unsigned y_w);
    return y_w;
  endfunction

  function automatic int unsigned hdr_src_y_lsb(input int unsigned x_w, input int unsigned y_w);
    return x_w + y_w;
  endfunction

  function automatic int unsigned hdr_src_x_lsb(input int unsigned x_w, input int unsigned y_w);
    return x_w + 2 * y_w;
  endfunction

  function automatic int unsigned hdr_count_lsb(input int unsigned x_w, input int unsigned y_w);
    return 2 * (x_w + y_w);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, id, last with valid/ready handshake.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]   tid;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport m (output tdata, output tid, output tvalid, output tlast, input tready);
  modport s (input tdata, input tid, input tvalid, input tlast, output tready);
endinterface

// File: rtl/packet_buffer.sv
// Payload store for one packet: register array with one write and one
// asynchronous read port.
module packet_buffer #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_packetizer.sv
// Buffers a raw AXI-Stream burst, then emits a routing header flit followed by
// the buffered payload; all out-side signals come straight from registers.
module axis_packetizer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int SRC_X         = 0,
  parameter int SRC_Y         = 0,
  parameter int MAX_PAYLOAD   = 4,
  localparam int X_W          = $clog2(MAX_ROUTERS_X),
  localparam int Y_W          = $clog2(MAX_ROUTERS_Y)
) (
  input  logic           clk,
  input  logic           rst_n,
  axis_if.s              in,
  input  logic [X_W-1:0] dest_x,
  input  logic [Y_W-1:0] dest_y,
  axis_if.m              out,
  output logic           busy
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int EW = DATA_WIDTH + ID_WIDTH;

  pkt_state_e            state_q;
  logic [CW-1:0]         wr_cnt_q, rd_ptr_q;
  logic [X_W-1:0]        dest_x_q;
  logic [Y_W-1:0]        dest_y_q;
  logic                  in_ready_q;
  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  logic                  in_fire, out_fire, first_beat;
  logic [CW-1:0]         wr_cnt_inc, rd_ptr_inc, rd_addr;
  logic [X_W-1:0]        hdr_dx;
  logic [Y_W-1:0]        hdr_dy;
  logic [EW-1:0]         buf_rdata;

  function automatic logic [DATA_WIDTH-1:0] build_header(
    input logic [X_W-1:0] dx,
    input logic [Y_W-1:0] dy,
    input logic [CW-1:0]  cnt
  );
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[HDR_DEST_Y_LSB +: Y_W]            = dy;
    h[hdr_dest_x_lsb(Y_W) +: X_W]       = dx;
    h[hdr_src_y_lsb(X_W, Y_W) +: Y_W]   = Y_W'(SRC_Y);
    h[hdr_src_x_lsb(X_W, Y_W) +: X_W]   = X_W'(SRC_X);
    h[hdr_count_lsb(X_W, Y_W) +: COUNT_W] = COUNT_W'(cnt);
    return h;
  endfunction

  assign in_fire    = in.tvalid && in_ready_q;
  assign out_fire   = out_valid_q && out.tready;
  assign first_beat = (wr_cnt_q == '0);
  assign wr_cnt_inc = wr_cnt_q + CW'(1);
  assign rd_ptr_inc = rd_ptr_q + CW'(1);
  // A single-beat packet must use the live destination, not the stale latch.
  assign hdr_dx     = first_beat ? dest_x : dest_x_q;
  assign hdr_dy     = first_beat ? dest_y : dest_y_q;
  // Prefetch the entry that becomes visible after the current out handshake.
  assign rd_addr    = (state_q == PKT_HEADER) ? '0 : rd_ptr_inc;

  packet_buffer #(
    .WIDTH(EW),
    .DEPTH(MAX_PAYLOAD)
  ) u_buf (
    .clk     (clk),
    .we_i    (in_fire),
    .waddr_i (wr_cnt_q[AW-1:0]),
    .wdata_i ({in.tdata, in.tid}),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PKT_FILL;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      case (state_q)
        PKT_FILL: begin
          if (in_fire) begin
            wr_cnt_q <= wr_cnt_inc;
            if (first_beat) begin
              dest_x_q <= dest_x;
              dest_y_q <= dest_y;
            end
            if (in.tlast || (wr_cnt_inc == CW'(MAX_PAYLOAD))) begin
              state_q     <= PKT_HEADER;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= build_header(hdr_dx, hdr_dy, wr_cnt_inc);
              out_id_q    <= ID_WIDTH'(ROUTING_HEADER);
              out_last_q  <= 1'b0;
            end
          end
        end
        PKT_HEADER: begin
          if (out_fire) begin
            state_q                <= PKT_DRAIN;
            rd_ptr_q               <= '0;
            {out_data_q, out_id_q} <= buf_rdata;
            out_last_q             <= (wr_cnt_q == CW'(1));
          end
        end
        PKT_DRAIN: begin
          if (out_fire) begin
            if (out_last_q) begin
              state_q     <= PKT_FILL;
              wr_cnt_q    <= '0;
              rd_ptr_q    <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              out_id_q    <= '0;
            end else begin
              rd_ptr_q               <= rd_ptr_inc;
              {out_data_q, out_id_q} <= buf_rdata;
              out_last_q             <= (rd_ptr_inc == wr_cnt_q - CW'(1));
            end
          end
        end
        default: state_q <= PKT_FILL;
      endcase
    end
  end

  assign in.tready  = in_ready_q;
  assign out.tvalid = out_valid_q;
  assign out.tdata  = out_data_q;
  assign out.tid    = out_id_q;
  assign out.tlast  = out_last_q;
  assign busy       = (state_q != PKT_FILL) || (wr_cnt_q != '0);

endmodule
